// File: rtl/vc_pop_scheduler_pkg.sv
// Shared types and defaults for the VC0/VC1 pop scheduler.
// State encoding matches the sched_state output.
package vc_pop_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SERVE = 2'd2,
        ST_STALL = 2'd3
    } sched_state_e;

    localparam int WEIGHT_RST_DEF = 3;
    localparam int STALL_W        = 8;

endpackage

// File: rtl/vc_pop_scheduler_wrr_grant.sv
// Weighted round-robin grant: VC0 wins while under its weight,
// or whenever VC1 is empty; VC1 takes the slot otherwise.
module vc_pop_scheduler_wrr_grant #(
    parameter int CNT_W    = 5,
    parameter int WEIGHT_W = 4
) (
    input  logic                can,
    input  logic [CNT_W-1:0]    eff0,
    input  logic [CNT_W-1:0]    eff1,
    input  logic [WEIGHT_W-1:0] burst,
    input  logic [WEIGHT_W-1:0] weight,
    output logic                g0,
    output logic                g1
);

    logic has0;
    logic has1;

    assign has0 = (eff0 != '0);
    assign has1 = (eff1 != '0);

    assign g0 = can && has0 && ((burst < weight) || !has1);
    assign g1 = can && has1 && !g0;

endmodule

// File: rtl/vc_pop_scheduler.sv
// Registered pop generator for the VC0/VC1 FIFOs with pause
// throttling, a weighted round-robin and a stall counter.
module vc_pop_scheduler
    import vc_pop_scheduler_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter int WEIGHT_W   = 4,
    parameter int WEIGHT_RST = WEIGHT_RST_DEF
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                init,
    input  logic [WEIGHT_W-1:0] weight_cfg,
    input  logic                pop_en,
    input  logic [CNT_W-1:0]    vc0_count,
    input  logic [CNT_W-1:0]    vc1_count,
    input  logic                pausa_d0,
    input  logic                pausa_d1,
    output logic                pop_vc0,
    output logic                pop_vc1,
    output logic [1:0]          sched_state,
    output logic [STALL_W-1:0]  stall_cnt
);

    sched_state_e        state;
    logic [WEIGHT_W-1:0] weight;
    logic [WEIGHT_W-1:0] burst;
    logic                pausa_q;
    logic [CNT_W-1:0]    eff0;
    logic [CNT_W-1:0]    eff1;
    logic                can;
    logic                pending;
    logic                g0;
    logic                g1;

    // Counts lag the registered pop by one cycle; clamp at zero.
    assign eff0 = (vc0_count == '0) ? '0 : vc0_count - CNT_W'(pop_vc0);
    assign eff1 = (vc1_count == '0) ? '0 : vc1_count - CNT_W'(pop_vc1);

    assign can     = pop_en && !pausa_q && (state != ST_INIT);
    assign pending = (eff0 != '0) || (eff1 != '0);

    assign sched_state = state;

    vc_pop_scheduler_wrr_grant #(
        .CNT_W    (CNT_W),
        .WEIGHT_W (WEIGHT_W)
    ) u_wrr_grant (
        .can    (can),
        .eff0   (eff0),
        .eff1   (eff1),
        .burst  (burst),
        .weight (weight),
        .g0     (g0),
        .g1     (g1)
    );

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state     <= ST_INIT;
            weight    <= WEIGHT_W'(WEIGHT_RST);
            burst     <= '0;
            pausa_q   <= 1'b0;
            pop_vc0   <= 1'b0;
            pop_vc1   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            pausa_q <= pausa_d0 | pausa_d1;
            if (init) begin
                state   <= ST_INIT;
                weight  <= (weight_cfg == '0) ? WEIGHT_W'(1) : weight_cfg;
                burst   <= '0;
                pop_vc0 <= 1'b0;
                pop_vc1 <= 1'b0;
            end else begin
                pop_vc0 <= g0;
                pop_vc1 <= g1;
                if (g1 || (eff0 == '0)) begin
                    burst <= '0;
                end else if (g0 && (burst < weight)) begin
                    burst <= burst + WEIGHT_W'(1);
                end
                if (state == ST_INIT) begin
                    state <= ST_IDLE;
                end else if (!pending) begin
                    state <= ST_IDLE;
                end else if (pausa_q || !pop_en) begin
                    state <= ST_STALL;
                    if (stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                end else begin
                    state <= ST_SERVE;
                end
            end
        end
    end

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Directed bench for vc_pop_scheduler: vector table plus
// hand-written multi-cycle sequences.
module tb_vc_pop_scheduler;

    logic       clk;
    logic       reset_L;
    logic       init;
    logic [3:0] weight_cfg;
    logic       pop_en;
    logic [4:0] vc0_count;
    logic [4:0] vc1_count;
    logic       pausa_d0;
    logic       pausa_d1;
    logic       pop_vc0;
    logic       pop_vc1;
    logic [1:0] sched_state;
    logic [7:0] stall_cnt;

    int checks;
    int failures;
    bit fifo_mode;

    vc_pop_scheduler dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .init        (init),
        .weight_cfg  (weight_cfg),
        .pop_en      (pop_en),
        .vc0_count   (vc0_count),
        .vc1_count   (vc1_count),
        .pausa_d0    (pausa_d0),
        .pausa_d1    (pausa_d1),
        .pop_vc0     (pop_vc0),
        .pop_vc1     (pop_vc1),
        .sched_state (sched_state),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst_l;
        bit       ini;
        bit [3:0] wcfg;
        bit       pe;
        bit [4:0] c0;
        bit [4:0] c1;
        bit       pd0;
        bit       pd1;
        bit       e0;
        bit       e1;
        bit [1:0] est;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit i, bit [3:0] w, bit pe,
                                bit [4:0] c0, bit [4:0] c1,
                                bit e0, bit e1, bit [1:0] st);
        vec_t v;
        v.rst_l = r;  v.ini = i;  v.wcfg = w;  v.pe = pe;
        v.c0 = c0;    v.c1 = c1;  v.pd0 = 1'b0; v.pd1 = 1'b0;
        v.e0 = e0;    v.e1 = e1;  v.est = st;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge; the FIFO model drains on the edge that samples a pop.
    task automatic tick();
        bit a0;
        bit a1;
        a0 = pop_vc0;
        a1 = pop_vc1;
        @(posedge clk);
        #1;
        if (fifo_mode) begin
            vc0_count = vc0_count - 5'(a0);
            vc1_count = vc1_count - 5'(a1);
        end
        if (pop_vc0 && pop_vc1) begin
            failures++;
            $display("FAIL both_pops: got 1 expected 0");
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        fifo_mode = 0;
        clk = 0;
        reset_L = 0;
        init = 0;
        weight_cfg = 0;
        pop_en = 1;
        vc0_count = 5;
        vc1_count = 0;
        pausa_d0 = 0;
        pausa_d1 = 0;

        // rst, init, wcfg, pe, c0, c1 | pop0, pop1, state
        vecs.push_back(mk(0, 0, 0, 1, 5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 5, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 5, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 5, 0, 1, 0, 2));
        vecs.push_back(mk(1, 1, 2, 1, 8, 8, 0, 0, 0));
        vecs.push_back(mk(1, 0, 2, 1, 8, 8, 0, 0, 1));
        vecs.push_back(mk(1, 0, 2, 1, 8, 8, 1, 0, 2));
        vecs.push_back(mk(1, 0, 2, 1, 8, 8, 1, 0, 2));
        vecs.push_back(mk(1, 0, 2, 1, 8, 8, 0, 1, 2));
        vecs.push_back(mk(1, 0, 2, 1, 8, 8, 1, 0, 2));
        vecs.push_back(mk(1, 0, 2, 1, 8, 8, 1, 0, 2));
        vecs.push_back(mk(1, 0, 2, 1, 8, 8, 0, 1, 2));
        vecs.push_back(mk(1, 0, 2, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 7, 1, 8, 8, 1, 0, 2));
        vecs.push_back(mk(1, 0, 7, 1, 8, 8, 1, 0, 2));
        vecs.push_back(mk(1, 0, 7, 1, 8, 8, 0, 1, 2));
        vecs.push_back(mk(1, 0, 7, 0, 8, 8, 0, 0, 3));
        vecs.push_back(mk(1, 0, 7, 1, 8, 8, 1, 0, 2));

        foreach (vecs[i]) begin
            reset_L    = vecs[i].rst_l;
            init       = vecs[i].ini;
            weight_cfg = vecs[i].wcfg;
            pop_en     = vecs[i].pe;
            vc0_count  = vecs[i].c0;
            vc1_count  = vecs[i].c1;
            pausa_d0   = vecs[i].pd0;
            pausa_d1   = vecs[i].pd1;
            tick();
            chk($sformatf("vec%0d_pop0", i), int'(pop_vc0), int'(vecs[i].e0));
            chk($sformatf("vec%0d_pop1", i), int'(pop_vc1), int'(vecs[i].e1));
            chk($sformatf("vec%0d_state", i), int'(sched_state), int'(vecs[i].est));
            if (!vecs[i].rst_l)
                chk($sformatf("vec%0d_stall_rst", i), int'(stall_cnt), 0);
        end
        chk("stall_after_table", int'(stall_cnt), 1);

        // Burst of exactly four pops from a 4-deep VC0, VC1 empty.
        init = 1; weight_cfg = 3; vc0_count = 0; vc1_count = 0;
        tick();
        init = 0;
        tick();
        tick();
        chk("drain_pre_state", int'(sched_state), 1);
        vc0_count = 4;
        fifo_mode = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("drain_pop0_t%0d", i), int'(pop_vc0), (i < 4) ? 1 : 0);
        end
        fifo_mode = 0;
        chk("drain_count", int'(vc0_count), 0);
        chk("drain_state", int'(sched_state), 1);

        // Count of one with a pop in flight must not pop again.
        vc0_count = 1;
        tick();
        chk("cnt1_first_pop", int'(pop_vc0), 1);
        tick();
        chk("cnt1_no_second", int'(pop_vc0), 0);
        chk("cnt1_state", int'(sched_state), 1);
        vc0_count = 0;
        tick();

        // Pause for five cycles in the middle of serving.
        vc0_count = 8; vc1_count = 8;
        tick();
        tick();
        chk("pause_pre_state", int'(sched_state), 2);
        pausa_d1 = 1;
        tick();
        chk("pause_inflight", int'(pop_vc0 | pop_vc1), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("pause_blk%0d", i), int'(pop_vc0 | pop_vc1), 0);
        end
        pausa_d1 = 0;
        tick();
        chk("pause_tail_pop", int'(pop_vc0 | pop_vc1), 0);
        chk("pause_tail_state", int'(sched_state), 3);
        tick();
        chk("resume_pop", int'(pop_vc0 | pop_vc1), 1);
        chk("resume_state", int'(sched_state), 2);
        chk("stall_total", int'(stall_cnt), 6);

        // Weight 0 behaves as 1: strict alternation.
        init = 1; weight_cfg = 0;
        tick();
        chk("w0_init_state", int'(sched_state), 0);
        chk("w0_init_pops", int'(pop_vc0 | pop_vc1), 0);
        init = 0;
        tick();
        chk("w0_idle_state", int'(sched_state), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("alt_pop0_%0d", i), int'(pop_vc0), (i % 2 == 0) ? 1 : 0);
            chk($sformatf("alt_pop1_%0d", i), int'(pop_vc1), (i % 2 == 1) ? 1 : 0);
        end
        chk("stall_final", int'(stall_cnt), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
